sram_axi_arbiter: RTL and testbench

- Two-master to one-slave AXI arbiter. It shares a single SRAM_wrapper slave port between master 0 (instruction fetch) and master 1 (data).
- Grants exactly one transaction at a time: one read burst, or one write burst including its B response. This matches the slave, which serializes all accesses.
- Extends master IDs to slave IDs and routes R and B responses back to the owning master.

---
 rtl/axi_arb_pkg.sv | 74 +++++++
 rtl/rr_arbiter2.sv | 21 ++
 rtl/sram_axi_arbiter.sv | 150 +++++++++++++++
 tb/tb_sram_axi_arbiter.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_arb_pkg.sv
// Shared AXI bundle types, ID widths and arbiter states
// for the two-master SRAM arbiter.
package axi_arb_pkg;

  localparam int IDM = 4;
  localparam int IDS = 8;

  typedef struct packed {
    logic [IDM-1:0] id;
    logic [31:0]    addr;
    logic [3:0]     len;
    logic [2:0]     size;
    logic [1:0]     burst;
    logic           valid;
  } axi_ar_t;

  typedef axi_ar_t axi_aw_t;

  typedef struct packed {
    logic [IDS-1:0] id;
    logic [31:0]    addr;
    logic [3:0]     len;
    logic [2:0]     size;
    logic [1:0]     burst;
    logic           valid;
  } axi_ars_t;

  typedef axi_ars_t axi_aws_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
    logic        valid;
  } axi_w_t;

  typedef struct packed {
    logic [IDM-1:0] id;
    logic [31:0]    data;
    logic [1:0]     resp;
    logic           last;
    logic           valid;
  } axi_r_t;

  typedef struct packed {
    logic [IDS-1:0] id;
    logic [31:0]    data;
    logic [1:0]     resp;
    logic           last;
    logic           valid;
  } axi_rs_t;

  typedef struct packed {
    logic [IDM-1:0] id;
    logic [1:0]     resp;
    logic           valid;
  } axi_b_t;

  typedef struct packed {
    logic [IDS-1:0] id;
    logic [1:0]     resp;
    logic           valid;
  } axi_bs_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_ADDR,
    WR_DATA,
    WR_RESP
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-request round-robin pick; favours the requester that
// did not win last when both ask.
module rr_arbiter2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       gnt_o,
  output logic       valid_o
);

  always_comb begin
    gnt_o = 1'b0;
    case (req_i)
      2'b11:   gnt_o = ~last_i;
      2'b10:   gnt_o = 1'b1;
      default: gnt_o = 1'b0;
    endcase
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/sram_axi_arbiter.sv
// Shares one SRAM AXI slave between fetch (M0) and data (M1),
// one read burst or one full write transaction at a time.
module sram_axi_arbiter
  import axi_arb_pkg::*;
(
  input  logic              ACLK,
  input  logic              ARESET,
  input  axi_ar_t     [1:0] m_ar,
  output logic        [1:0] m_arready,
  output axi_r_t      [1:0] m_r,
  input  logic        [1:0] m_rready,
  input  axi_aw_t     [1:0] m_aw,
  output logic        [1:0] m_awready,
  input  axi_w_t      [1:0] m_w,
  output logic        [1:0] m_wready,
  output axi_b_t      [1:0] m_b,
  input  logic        [1:0] m_bready,
  output axi_ars_t          s_ar,
  input  logic              s_arready,
  input  axi_rs_t           s_r,
  output logic              s_rready,
  output axi_aws_t          s_aw,
  input  logic              s_awready,
  output axi_w_t            s_w,
  input  logic              s_wready,
  input  axi_bs_t           s_b,
  output logic              s_bready,
  output logic              busy
);

  arb_state_t state_q, state_d;
  logic       owner_q, owner_d;
  logic       is_write_q, is_write_d;
  logic       last_owner_q, last_owner_d;

  logic [1:0] req;
  logic       gnt;
  logic       gnt_vld;
  logic [IDS-IDM-1:0] id_hi;

  assign req[0] = m_ar[0].valid | m_aw[0].valid;
  assign req[1] = m_ar[1].valid | m_aw[1].valid;
  assign id_hi  = {{(IDS-IDM-1){1'b0}}, owner_q};

  rr_arbiter2 u_rr (
    .req_i   (req),
    .last_i  (last_owner_q),
    .gnt_o   (gnt),
    .valid_o (gnt_vld)
  );

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      is_write_q   <= 1'b0;
      last_owner_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      is_write_q   <= is_write_d;
      last_owner_q <= last_owner_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    is_write_d   = is_write_q;
    last_owner_d = last_owner_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          owner_d    = gnt;
          // reads win over writes from the same master
          is_write_d = ~m_ar[gnt].valid;
          state_d    = m_ar[gnt].valid ? RD_ADDR : WR_ADDR;
        end
      end
      RD_ADDR: begin
        if (m_ar[owner_q].valid && s_arready) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (s_r.valid && m_rready[owner_q] && s_r.last) begin
          last_owner_d = owner_q;
          state_d      = IDLE;
        end
      end
      WR_ADDR: begin
        if (m_aw[owner_q].valid && s_awready) state_d = WR_DATA;
      end
      WR_DATA: begin
        if (m_w[owner_q].valid && s_wready && m_w[owner_q].last)
          state_d = WR_RESP;
      end
      WR_RESP: begin
        if (s_b.valid && m_bready[owner_q]) begin
          last_owner_d = owner_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_arready = '0;
    m_awready = '0;
    m_wready  = '0;
    m_r       = '0;
    m_b       = '0;
    s_ar      = '0;
    s_aw      = '0;
    s_w       = '0;
    s_rready  = 1'b0;
    s_bready  = 1'b0;
    unique case (state_q)
      RD_ADDR: begin
        s_ar       = {id_hi, m_ar[owner_q].id, m_ar[owner_q].addr,
                      m_ar[owner_q].len, m_ar[owner_q].size,
                      m_ar[owner_q].burst, m_ar[owner_q].valid};
        m_arready[owner_q] = s_arready;
      end
      RD_DATA: begin
        // upper ID bits are not checked: only one burst is outstanding
        m_r[owner_q] = {s_r.id[IDM-1:0], s_r.data, s_r.resp,
                        s_r.last, s_r.valid};
        s_rready     = m_rready[owner_q];
      end
      WR_ADDR: begin
        s_aw       = {id_hi, m_aw[owner_q].id, m_aw[owner_q].addr,
                      m_aw[owner_q].len, m_aw[owner_q].size,
                      m_aw[owner_q].burst, m_aw[owner_q].valid};
        m_awready[owner_q] = s_awready;
      end
      WR_DATA: begin
        s_w               = m_w[owner_q];
        m_wready[owner_q] = s_wready;
      end
      WR_RESP: begin
        m_b[owner_q] = {s_b.id[IDM-1:0], s_b.resp, s_b.valid};
        s_bready     = m_bready[owner_q];
      end
      default: ;
    endcase
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_sram_axi_arbiter.sv
// Scoreboard bench for sram_axi_arbiter with a simple
// in-order SRAM slave model.
module tb_sram_axi_arbiter;
  import axi_arb_pkg::*;

  logic ACLK = 1'b0;
  logic ARESET;
  axi_ar_t  [1:0] m_ar;
  logic     [1:0] m_arready;
  axi_r_t   [1:0] m_r;
  logic     [1:0] m_rready;
  axi_aw_t  [1:0] m_aw;
  logic     [1:0] m_awready;
  axi_w_t   [1:0] m_w;
  logic     [1:0] m_wready;
  axi_b_t   [1:0] m_b;
  logic     [1:0] m_bready;
  axi_ars_t s_ar;
  logic     s_arready;
  axi_rs_t  s_r;
  logic     s_rready;
  axi_aws_t s_aw;
  logic     s_awready;
  axi_w_t   s_w;
  logic     s_wready;
  axi_bs_t  s_b;
  logic     s_bready;
  logic     busy;

  sram_axi_arbiter dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .m_ar(m_ar), .m_arready(m_arready),
    .m_r(m_r), .m_rready(m_rready),
    .m_aw(m_aw), .m_awready(m_awready),
    .m_w(m_w), .m_wready(m_wready),
    .m_b(m_b), .m_bready(m_bready),
    .s_ar(s_ar), .s_arready(s_arready),
    .s_r(s_r), .s_rready(s_rready),
    .s_aw(s_aw), .s_awready(s_awready),
    .s_w(s_w), .s_wready(s_wready),
    .s_b(s_b), .s_bready(s_bready),
    .busy(busy)
  );

  always #5 ACLK = ~ACLK;

  int errors = 0;
  int checks = 0;

  typedef struct { logic [7:0] id; logic [31:0] addr; logic [3:0] len; } ex_a_t;
  typedef struct { int m; logic [3:0] id; logic [31:0] data; logic last; } ex_r_t;
  typedef struct { logic [31:0] data; logic [3:0] strb; logic last; } ex_w_t;
  typedef struct { int m; logic [3:0] id; logic [1:0] resp; } ex_b_t;

  ex_a_t exp_ar[$];
  ex_a_t exp_aw[$];
  ex_r_t exp_r[$];
  ex_w_t exp_w[$];
  ex_b_t exp_b[$];

  logic [31:0] wd[2][4];
  logic [3:0]  ws[2][4];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    checks++;
    errors++;
    $display("FAIL %s", nm);
  endtask

  function automatic void push_r(input int m, input logic [3:0] id,
                                 input logic [31:0] a, input int n);
    for (int k = 0; k <= n; k++)
      exp_r.push_back('{m, id, a + k, k == n});
  endfunction

  // slave: always ready for AR/AW/W, R data = addr + beat index
  logic        rd_act, b_act;
  logic [7:0]  rd_id, w_id;
  logic [31:0] rd_addr;
  logic [3:0]  rd_cnt, rd_len;

  always_comb begin
    s_r       = '0;
    s_r.id    = rd_id;
    s_r.data  = rd_addr + {28'd0, rd_cnt};
    s_r.last  = (rd_cnt == rd_len);
    s_r.valid = rd_act;
    s_b       = '0;
    s_b.id    = w_id;
    s_b.valid = b_act;
  end

  initial begin : slave
    logic h_ar, h_r, h_aw, h_wl, h_b, rst;
    logic [7:0] c_id, c_wid;
    logic [31:0] c_addr;
    logic [3:0] c_len;
    rd_act = 0; b_act = 0; rd_id = 0; w_id = 0;
    rd_addr = 0; rd_cnt = 0; rd_len = 0;
    forever begin
      @(negedge ACLK);
      rst   = ARESET;
      h_ar  = s_ar.valid & s_arready;
      h_r   = s_r.valid & s_rready;
      h_aw  = s_aw.valid & s_awready;
      h_wl  = s_w.valid & s_wready & s_w.last;
      h_b   = s_b.valid & s_bready;
      c_id  = s_ar.id;
      c_addr = s_ar.addr;
      c_len = s_ar.len;
      c_wid = s_aw.id;
      @(posedge ACLK);
      #1;
      if (rst) begin
        rd_act = 0;
        b_act  = 0;
      end else begin
        if (h_ar) begin
          rd_act = 1; rd_id = c_id; rd_addr = c_addr;
          rd_cnt = 0; rd_len = c_len;
        end
        if (h_r) begin
          if (rd_cnt == rd_len) rd_act = 0;
          else rd_cnt = rd_cnt + 1;
        end
        if (h_aw) w_id = c_wid;
        if (h_wl) b_act = 1;
        if (h_b) b_act = 0;
      end
    end
  end

  initial begin : monitor
    ex_a_t ea;
    ex_r_t er;
    ex_w_t ew;
    ex_b_t eb;
    forever begin
      @(negedge ACLK);
      if (!ARESET) begin
        if (s_ar.valid && s_arready) begin
          if (exp_ar.size() == 0) flag("unexpected s_ar");
          else begin
            ea = exp_ar.pop_front();
            chk("ar.id", s_ar.id, ea.id);
            chk("ar.addr", s_ar.addr, ea.addr);
            chk("ar.len", s_ar.len, ea.len);
          end
        end
        if (s_aw.valid && s_awready) begin
          if (exp_aw.size() == 0) flag("unexpected s_aw");
          else begin
            ea = exp_aw.pop_front();
            chk("aw.id", s_aw.id, ea.id);
            chk("aw.addr", s_aw.addr, ea.addr);
            chk("aw.len", s_aw.len, ea.len);
          end
        end
        if (s_w.valid && s_wready) begin
          if (exp_w.size() == 0) flag("unexpected s_w");
          else begin
            ew = exp_w.pop_front();
            chk("w.data", s_w.data, ew.data);
            chk("w.strb", s_w.strb, ew.strb);
            chk("w.last", s_w.last, ew.last);
          end
        end
        for (int i = 0; i < 2; i++) begin
          if (m_r[i].valid && m_rready[i]) begin
            if (exp_r.size() == 0) flag("unexpected m_r");
            else begin
              er = exp_r.pop_front();
              chk("r.master", i, er.m);
              chk("r.id", m_r[i].id, er.id);
              chk("r.data", m_r[i].data, er.data);
              chk("r.last", m_r[i].last, er.last);
              chk("r.route", s_r.id[7:4], i);
            end
          end
          if (m_b[i].valid && m_bready[i]) begin
            if (exp_b.size() == 0) flag("unexpected m_b");
            else begin
              eb = exp_b.pop_front();
              chk("b.master", i, eb.m);
              chk("b.id", m_b[i].id, eb.id);
              chk("b.resp", m_b[i].resp, eb.resp);
              chk("b.route", s_b.id[7:4], i);
            end
          end
        end
        if (m_r[0].valid && m_r[1].valid) flag("r.both_valid");
        if (m_b[0].valid && m_b[1].valid) flag("b.both_valid");
      end
    end
  end

  task automatic rd(input int m, input logic [3:0] id,
                    input logic [31:0] addr, input logic [3:0] len);
    int t = 0;
    m_ar[m] = '{id: id, addr: addr, len: len, size: 3'd2,
                burst: 2'd1, valid: 1'b1};
    @(negedge ACLK);
    while (!m_arready[m] && t < 300) begin @(negedge ACLK); t++; end
    if (t >= 300) flag("timeout arready");
    @(posedge ACLK); #1;
    m_ar[m].valid = 1'b0;
  endtask

  task automatic wr(input int m, input logic [3:0] id,
                    input logic [31:0] addr, input logic [3:0] len);
    int t = 0;
    m_aw[m] = '{id: id, addr: addr, len: len, size: 3'd2,
                burst: 2'd1, valid: 1'b1};
    @(negedge ACLK);
    while (!m_awready[m] && t < 300) begin @(negedge ACLK); t++; end
    if (t >= 300) flag("timeout awready");
    @(posedge ACLK); #1;
    m_aw[m].valid = 1'b0;
    for (int k = 0; k <= int'(len); k++) begin
      m_w[m] = '{data: wd[m][k], strb: ws[m][k],
                 last: (k == int'(len)), valid: 1'b1};
      t = 0;
      @(negedge ACLK);
      while (!m_wready[m] && t < 300) begin @(negedge ACLK); t++; end
      if (t >= 300) flag("timeout wready");
      @(posedge ACLK); #1;
    end
    m_w[m] = '0;
  endtask

  task automatic drain(input string nm);
    int t = 0;
    do begin
      @(negedge ACLK); #1; t++;
    end while ((exp_ar.size() + exp_aw.size() + exp_w.size() +
                exp_r.size() + exp_b.size()) != 0 && t < 400);
    if (t >= 400) flag({nm, ".drain_timeout"});
    @(negedge ACLK);
    chk({nm, ".busy_low"}, busy, 0);
  endtask

  task automatic reset_dut();
    @(posedge ACLK); #1;
    ARESET = 1'b1;
    repeat (2) @(posedge ACLK);
    #1;
    ARESET = 1'b0;
  endtask

  task automatic chk_quiet(input string nm);
    chk(nm, {s_ar.valid, s_aw.valid, s_w.valid, s_rready, s_bready,
             m_arready, m_awready, m_wready, m_r[0].valid, m_r[1].valid,
             m_b[0].valid, m_b[1].valid, busy}, 0);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int t;
    ARESET = 1'b1;
    m_ar = '0; m_aw = '0; m_w = '0;
    m_rready = 2'b11; m_bready = 2'b11;
    s_arready = 1'b1; s_awready = 1'b1; s_wready = 1'b1;
    repeat (3) @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    @(negedge ACLK);
    chk_quiet("reset.outputs");

    // single read, one IDLE cycle then slave sees AR
    exp_ar.push_back('{8'h05, 32'h10, 4'd3});
    push_r(0, 4'h5, 32'h10, 3);
    @(posedge ACLK); #1;
    m_ar[0] = '{id: 4'h5, addr: 32'h10, len: 4'd3, size: 3'd2,
                burst: 2'd1, valid: 1'b1};
    @(negedge ACLK);
    chk("t1.idle_cycle", {busy, s_ar.valid}, 0);
    @(negedge ACLK);
    chk("t1.ar_cycle1", {s_ar.valid, s_ar.id}, {1'b1, 8'h05});
    @(posedge ACLK); #1;
    m_ar[0].valid = 1'b0;
    drain("t1");

    // contention after reset: M0, M1, then M0 again
    reset_dut();
    exp_ar.push_back('{8'h01, 32'h20, 4'd0});
    exp_ar.push_back('{8'h13, 32'h40, 4'd1});
    push_r(0, 4'h1, 32'h20, 0);
    push_r(1, 4'h3, 32'h40, 1);
    fork
      rd(0, 4'h1, 32'h20, 4'd0);
      rd(1, 4'h3, 32'h40, 4'd1);
    join
    drain("t2a");
    exp_ar.push_back('{8'h02, 32'h60, 4'd0});
    exp_ar.push_back('{8'h14, 32'h80, 4'd0});
    push_r(0, 4'h2, 32'h60, 0);
    push_r(1, 4'h4, 32'h80, 0);
    fork
      rd(0, 4'h2, 32'h60, 4'd0);
      rd(1, 4'h4, 32'h80, 4'd0);
    join
    drain("t2b");

    // M1 two-beat write burst
    wd[1][0] = 32'hDEADBEEF; ws[1][0] = 4'hF;
    wd[1][1] = 32'h12345678; ws[1][1] = 4'h3;
    exp_aw.push_back('{8'h12, 32'h100, 4'd1});
    exp_w.push_back('{32'hDEADBEEF, 4'hF, 1'b0});
    exp_w.push_back('{32'h12345678, 4'h3, 1'b1});
    exp_b.push_back('{1, 4'h2, 2'b00});
    wr(1, 4'h2, 32'h100, 4'd1);
    drain("t3");

    // M0 read+write together, M1 write slots in between
    reset_dut();
    wd[0][0] = 32'hCAFE0000; ws[0][0] = 4'hF;
    wd[1][0] = 32'h0BADF00D; ws[1][0] = 4'h1;
    exp_ar.push_back('{8'h0A, 32'h200, 4'd1});
    push_r(0, 4'hA, 32'h200, 1);
    exp_aw.push_back('{8'h17, 32'h300, 4'd0});
    exp_aw.push_back('{8'h0B, 32'h280, 4'd0});
    exp_w.push_back('{32'h0BADF00D, 4'h1, 1'b1});
    exp_w.push_back('{32'hCAFE0000, 4'hF, 1'b1});
    exp_b.push_back('{1, 4'h7, 2'b00});
    exp_b.push_back('{0, 4'hB, 2'b00});
    fork
      rd(0, 4'hA, 32'h200, 4'd1);
      wr(0, 4'hB, 32'h280, 4'd0);
      wr(1, 4'h7, 32'h300, 4'd0);
    join
    drain("t4");

    // R backpressure for 5 cycles after first beat
    exp_ar.push_back('{8'h06, 32'h400, 4'd3});
    push_r(0, 4'h6, 32'h400, 3);
    fork
      rd(0, 4'h6, 32'h400, 4'd3);
      begin
        t = 0;
        @(negedge ACLK);
        while (!m_r[0].valid && t < 300) begin @(negedge ACLK); t++; end
        if (t >= 300) flag("t5.timeout_first_beat");
        @(posedge ACLK); #1;
        m_rready[0] = 1'b0;
        repeat (5) begin
          @(negedge ACLK);
          chk("t5.s_rready", s_rready, 0);
          chk("t5.hold", {m_r[0].valid, m_r[0].data}, {1'b1, 32'h401});
        end
        m_rready[0] = 1'b1;
      end
    join
    drain("t5");

    // reset in WR_DATA after one of four beats
    for (int k = 0; k < 4; k++) begin
      wd[0][k] = 32'h5000 + k; ws[0][k] = 4'hF;
    end
    exp_aw.push_back('{8'h0C, 32'h500, 4'd3});
    exp_w.push_back('{32'h5000, 4'hF, 1'b0});
    @(posedge ACLK); #1;
    m_aw[0] = '{id: 4'hC, addr: 32'h500, len: 4'd3, size: 3'd2,
                burst: 2'd1, valid: 1'b1};
    t = 0;
    @(negedge ACLK);
    while (!m_awready[0] && t < 300) begin @(negedge ACLK); t++; end
    if (t >= 300) flag("t6.timeout_aw");
    @(posedge ACLK); #1;
    m_aw[0].valid = 1'b0;
    m_w[0] = '{data: wd[0][0], strb: 4'hF, last: 1'b0, valid: 1'b1};
    t = 0;
    @(negedge ACLK);
    while (!m_wready[0] && t < 300) begin @(negedge ACLK); t++; end
    if (t >= 300) flag("t6.timeout_w");
    @(posedge ACLK); #1;
    m_w[0] = '{data: wd[0][1], strb: 4'hF, last: 1'b0, valid: 1'b1};
    ARESET = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    chk_quiet("t6.after_reset");
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    m_w[0] = '0;
    @(negedge ACLK);
    chk_quiet("t6.idle");

    repeat (3) @(negedge ACLK);
    chk("end.queues", exp_ar.size() + exp_aw.size() + exp_w.size() +
                      exp_r.size() + exp_b.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
